// File: rtl/tpu_cmd_sequencer.sv
// TPU command sequencer: buffers host commands in a small FIFO and issues them
// to the systolic core as registered drives. Single-shot ops last one cycle,
// matmul holds the core for MM_CYCLES cycles, and readC results are captured
// into a single-entry response register that back-pressures further readCs.
// DIM must be at least 8: lanes 0..3 feed v_low and lanes 4..7 feed v_high.
// FIFO_DEPTH must be a power of two and at least 2 so the pointers wrap naturally.

module tpu_payload_lane #(
  parameter int VEC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VEC_W-1:0] d,
  output logic [VEC_W-1:0] q
);
  // Hold the issued element for one cycle, idle at zero otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
    else           q <= '0;
  end
endmodule

module tpu_cmd_sequencer #(
  parameter int DIM        = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int MM_CYCLES  = 3*DIM-2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [3:0]           cmd_idx,
  input  logic                 cmd_hl,
  input  logic [DIM-1:0][31:0] cmd_data,
  output logic [2:0]           tpu_opcode,
  output logic [3:0]           tpu_idx,
  output logic                 tpu_hl,
  output logic [3:0][31:0]     tpu_v_low,
  output logic [3:0][31:0]     tpu_v_high,
  input  logic [3:0][31:0]     tpu_data_out,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [3:0][31:0]     rsp_data,
  output logic                 mm_done,
  output logic                 busy,
  output logic                 err
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 32;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int CNTW      = $clog2(FIFO_DEPTH + 1);
  localparam int MCW       = $clog2(MM_CYCLES + 1);
  localparam logic [MCW-1:0] MM_LAST = MCW'(MM_CYCLES - 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WRA     = 3'd1;
  localparam logic [2:0] OP_WRB     = 3'd2;
  localparam logic [2:0] OP_WRC     = 3'd3;
  localparam logic [2:0] OP_MATMUL  = 3'd4;
  localparam logic [2:0] OP_READC   = 3'd5;
  localparam logic [2:0] OP_STEP    = 3'd6;
  localparam logic [2:0] OP_ILLEGAL = 3'd7;

  typedef struct packed {
    logic [2:0]           op;
    logic [3:0]           idx;
    logic                 hl;
    logic [DIM-1:0][31:0] data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_MATMUL, S_RDWAIT} state_t;

  cmd_t            fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_cnt;
  cmd_t            head;
  logic            fifo_empty, push, pop;

  state_t          state, state_nxt;
  logic [MCW-1:0]  mm_cnt, mm_cnt_nxt;
  logic [2:0]      op_nxt;
  logic [3:0]      idx_nxt;
  logic            hl_nxt, load_nxt, err_nxt, mm_done_nxt, rd_blocked;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (fifo_cnt == '0);
  assign cmd_ready  = (fifo_cnt < CNTW'(FIFO_DEPTH));
  assign push       = cmd_valid && cmd_ready;
  assign busy       = !fifo_empty || (state != S_IDLE) || (tpu_opcode != OP_NOP);

  // Command storage; contents are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{op: cmd_op, idx: cmd_idx, hl: cmd_hl, data: cmd_data};
  end

  // FIFO pointers and occupancy; a full FIFO never accepts, even while popping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Issue decision: what the core sees next cycle and whether the head is consumed
  always_comb begin
    state_nxt   = state;
    mm_cnt_nxt  = mm_cnt;
    pop         = 1'b0;
    op_nxt      = OP_NOP;
    idx_nxt     = '0;
    hl_nxt      = 1'b0;
    load_nxt    = 1'b0;
    err_nxt     = 1'b0;
    mm_done_nxt = 1'b0;
    // A readC must wait while a response is held or still in flight to the register
    rd_blocked  = rsp_valid || (tpu_opcode == OP_READC);
    case (state)
      S_IDLE, S_RDWAIT: begin
        if (!fifo_empty) begin
          case (head.op)
            OP_MATMUL: begin
              pop        = 1'b1;
              state_nxt  = S_MATMUL;
              mm_cnt_nxt = '0;
              op_nxt     = OP_MATMUL;
            end
            OP_READC: begin
              if (rd_blocked) begin
                state_nxt = S_RDWAIT;
              end else begin
                pop       = 1'b1;
                state_nxt = S_IDLE;
                op_nxt    = OP_READC;
                idx_nxt   = head.idx;
                hl_nxt    = head.hl;
              end
            end
            OP_WRA, OP_WRB, OP_WRC, OP_STEP: begin
              pop      = 1'b1;
              op_nxt   = head.op;
              idx_nxt  = head.idx;
              hl_nxt   = head.hl;
              load_nxt = 1'b1;
            end
            OP_ILLEGAL: begin
              pop     = 1'b1;
              err_nxt = 1'b1;
            end
            default: pop = 1'b1;
          endcase
        end
      end
      S_MATMUL: begin
        if (mm_cnt == MM_LAST) begin
          state_nxt   = S_IDLE;
          mm_cnt_nxt  = '0;
          mm_done_nxt = 1'b1;
        end else begin
          mm_cnt_nxt = mm_cnt + MCW'(1);
          op_nxt     = OP_MATMUL;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, matmul counter and registered core controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      mm_cnt     <= '0;
      tpu_opcode <= OP_NOP;
      tpu_idx    <= '0;
      tpu_hl     <= 1'b0;
      err        <= 1'b0;
      mm_done    <= 1'b0;
    end else begin
      state      <= state_nxt;
      mm_cnt     <= mm_cnt_nxt;
      tpu_opcode <= op_nxt;
      tpu_idx    <= idx_nxt;
      tpu_hl     <= hl_nxt;
      err        <= err_nxt;
      mm_done    <= mm_done_nxt;
    end
  end

  // readC response: capture at the end of the drive cycle, clear on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (tpu_opcode == OP_READC) begin
      rsp_valid <= 1'b1;
      rsp_data  <= tpu_data_out;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Payload lanes: 0..3 drive v_low, 4..7 drive v_high
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_q;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    tpu_payload_lane #(.VEC_W(VEC_W)) u_lane (
      .clk  (clk),
      .rst  (rst),
      .load (load_nxt),
      .d    (head.data[l]),
      .q    (lane_q[l])
    );
  end

  assign tpu_v_low  = lane_q[3:0];
  assign tpu_v_high = lane_q[7:4];
endmodule

// File: tb/tb_tpu_cmd_sequencer.sv
// Bench for tpu_cmd_sequencer: directed scenarios plus a random phase, all
// checked every cycle against a queue-based reference model.
module tb_tpu_cmd_sequencer;
  localparam int DIM   = 8;
  localparam int DEPTH = 4;
  localparam int MM    = 3*DIM-2;

  typedef logic [DIM-1:0][31:0] data_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [3:0]       cmd_idx = '0;
  logic             cmd_hl = 1'b0;
  data_t            cmd_data = '0;
  logic [2:0]       tpu_opcode;
  logic [3:0]       tpu_idx;
  logic             tpu_hl;
  logic [3:0][31:0] tpu_v_low, tpu_v_high, rsp_data;
  logic [3:0][31:0] tpu_data_out = '0;
  logic             rsp_valid, mm_done, busy, err;
  logic             rsp_ready = 1'b0;

  tpu_cmd_sequencer #(.DIM(DIM), .FIFO_DEPTH(DEPTH), .MM_CYCLES(MM)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_idx(cmd_idx), .cmd_hl(cmd_hl), .cmd_data(cmd_data),
    .tpu_opcode(tpu_opcode), .tpu_idx(tpu_idx), .tpu_hl(tpu_hl),
    .tpu_v_low(tpu_v_low), .tpu_v_high(tpu_v_high), .tpu_data_out(tpu_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mm_done(mm_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: pending commands, remaining matmul cycles, expected outputs
  typedef struct {
    logic [2:0] op;
    logic [3:0] idx;
    logic       hl;
    data_t      data;
  } mcmd_t;

  mcmd_t            q[$];
  int               mm_left;
  logic [2:0]       e_op;
  logic [3:0]       e_idx;
  logic             e_hl, e_rsp_valid, e_mm_done, e_err, acc;
  logic [3:0][31:0] e_low, e_high, e_rsp_data;

  int checks = 0;
  int errors = 0;
  int n4, n5, nd;
  logic       prev_done;
  logic [2:0] op_after_done;

  task automatic model_reset();
    q.delete();
    mm_left = 0;
    e_op = '0; e_idx = '0; e_hl = 1'b0; e_low = '0; e_high = '0;
    e_rsp_valid = 1'b0; e_rsp_data = '0; e_mm_done = 1'b0; e_err = 1'b0;
    acc = 1'b0;
  endtask

  task automatic model_edge();
    mcmd_t h, c;
    logic [2:0] n_op;
    logic [3:0] n_idx;
    logic n_hl, n_rv, n_mm, n_err;
    logic [3:0][31:0] n_low, n_high, n_rd;
    if (rst) begin
      model_reset();
      return;
    end
    acc  = cmd_valid && (q.size() < DEPTH);
    n_rv = e_rsp_valid;
    n_rd = e_rsp_data;
    if (e_op == 3'd5) begin
      n_rv = 1'b1;
      n_rd = tpu_data_out;
    end else if (e_rsp_valid && rsp_ready) begin
      n_rv = 1'b0;
    end
    n_op = '0; n_idx = '0; n_hl = 1'b0; n_low = '0; n_high = '0; n_mm = 1'b0; n_err = 1'b0;
    if (mm_left > 0) begin
      mm_left--;
      if (mm_left == 0) n_mm = 1'b1;
      else              n_op = 3'd4;
    end else if (q.size() > 0) begin
      h = q[0];
      if (!(h.op == 3'd5 && (e_rsp_valid || e_op == 3'd5))) begin
        h = q.pop_front();
        case (h.op)
          3'd1, 3'd2, 3'd3, 3'd6: begin
            n_op = h.op; n_idx = h.idx; n_hl = h.hl;
            n_low = h.data[3:0]; n_high = h.data[7:4];
          end
          3'd4: begin n_op = 3'd4; mm_left = MM; end
          3'd5: begin n_op = 3'd5; n_idx = h.idx; n_hl = h.hl; end
          3'd7: n_err = 1'b1;
          default: ;
        endcase
      end
    end
    if (acc) begin
      c.op = cmd_op; c.idx = cmd_idx; c.hl = cmd_hl; c.data = cmd_data;
      q.push_back(c);
    end
    e_op = n_op; e_idx = n_idx; e_hl = n_hl; e_low = n_low; e_high = n_high;
    e_mm_done = n_mm; e_err = n_err; e_rsp_valid = n_rv; e_rsp_data = n_rd;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("tpu_opcode", 256'(tpu_opcode), 256'(e_op));
    check("tpu_idx", 256'(tpu_idx), 256'(e_idx));
    check("tpu_hl", 256'(tpu_hl), 256'(e_hl));
    if (e_op != 3'd5) begin
      check("tpu_v_low", 256'(tpu_v_low), 256'(e_low));
      check("tpu_v_high", 256'(tpu_v_high), 256'(e_high));
    end
    check("mm_done", 256'(mm_done), 256'(e_mm_done));
    check("err", 256'(err), 256'(e_err));
    check("rsp_valid", 256'(rsp_valid), 256'(e_rsp_valid));
    check("rsp_data", 256'(rsp_data), 256'(e_rsp_data));
    check("busy", 256'(busy), 256'(q.size() > 0 || mm_left > 0 || e_op != 3'd0));
    check("cmd_ready", 256'(cmd_ready), 256'(q.size() < DEPTH));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    if (tpu_opcode == 3'd4) n4++;
    if (tpu_opcode == 3'd5) n5++;
    if (prev_done) op_after_done = tpu_opcode;
    prev_done = mm_done;
    if (mm_done) nd++;
  endtask

  task automatic send(input logic [2:0] op, input logic [3:0] idx, input logic hl, input data_t d);
    int guard;
    guard = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_idx = idx; cmd_hl = hl; cmd_data = d;
    do begin
      cycle();
      guard++;
    end while (!acc && guard < 100);
    check("send_accept_timeout", 256'(acc), 256'(1));
    cmd_valid = 1'b0;
  endtask

  function automatic data_t rnd_data();
    data_t r;
    for (int i = 0; i < DIM; i++) r[i] = $urandom;
    return r;
  endfunction

  function automatic logic [2:0] rnd_op();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      return 3'd4;
    else if (r <= 2) return 3'd5;
    else if (r == 3) return 3'd7;
    else if (r == 4) return 3'd0;
    else begin
      case ($urandom_range(0, 3))
        0:       return 3'd1;
        1:       return 3'd2;
        2:       return 3'd3;
        default: return 3'd6;
      endcase
    end
  endfunction

  initial begin
    data_t d;
    int guard;
    model_reset();
    n4 = 0; n5 = 0; nd = 0; prev_done = 1'b0; op_after_done = '0;

    // Power-up reset
    #3;
    check_all();
    check("reset_cmd_ready", 256'(cmd_ready), 256'(1));
    check("reset_busy", 256'(busy), 256'(0));
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // writeA idx 3 with element i = i*0x11: driven exactly one cycle
    for (int i = 0; i < DIM; i++) d[i] = 32'(i * 17);
    send(3'd1, 4'd3, 1'b0, d);
    cycle();
    check("wra_opcode", 256'(tpu_opcode), 256'(1));
    check("wra_idx", 256'(tpu_idx), 256'(3));
    check("wra_vlow0", 256'(tpu_v_low[0]), 256'(0));
    check("wra_vhigh3", 256'(tpu_v_high[3]), 256'(32'h77));
    cycle();
    check("wra_one_cycle", 256'(tpu_opcode), 256'(0));

    // Back-to-back single-cycle commands
    for (int k = 0; k < 6; k++) begin
      case (k % 4)
        0: send(3'd1, 4'($urandom), 1'($urandom), rnd_data());
        1: send(3'd2, 4'($urandom), 1'($urandom), rnd_data());
        2: send(3'd3, 4'($urandom), 1'($urandom), rnd_data());
        default: send(3'd6, 4'($urandom), 1'($urandom), rnd_data());
      endcase
    end
    send(3'd0, 4'd9, 1'b1, rnd_data());
    for (int k = 0; k < 4; k++) cycle();

    // matmul then writeB
    n4 = 0; nd = 0; op_after_done = '0;
    send(3'd4, 4'd0, 1'b0, rnd_data());
    send(3'd2, 4'd5, 1'b1, rnd_data());
    for (int k = 0; k < 30; k++) cycle();
    check("mm_cycles", 256'(n4), 256'(22));
    check("mm_done_pulses", 256'(nd), 256'(1));
    check("op_after_mm_done", 256'(op_after_done), 256'(2));

    // FIFO fill while stalled by matmul
    send(3'd4, 4'd0, 1'b0, rnd_data());
    for (int k = 0; k < 4; k++) send(3'd1, 4'(k), 1'b0, rnd_data());
    check("full_cmd_ready", 256'(cmd_ready), 256'(0));
    cmd_valid = 1'b1; cmd_op = 3'd3; cmd_idx = 4'd7; cmd_data = rnd_data();
    cycle();
    check("full_no_accept", 256'(acc), 256'(0));
    check("full_cmd_ready_hold", 256'(cmd_ready), 256'(0));
    send(3'd3, 4'd7, 1'b0, cmd_data);
    for (int k = 0; k < 8; k++) cycle();

    // Two readC with response stalled
    rsp_ready = 1'b0;
    tpu_data_out = {4{32'hA5A5A5A5}};
    n5 = 0;
    send(3'd5, 4'd1, 1'b0, rnd_data());
    send(3'd5, 4'd2, 1'b1, rnd_data());
    for (int k = 0; k < 8; k++) cycle();
    check("rdc_rsp_valid", 256'(rsp_valid), 256'(1));
    check("rdc_rsp_data", 256'(rsp_data), 256'({4{32'hA5A5A5A5}}));
    check("rdc_second_held", 256'(n5), 256'(1));
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    tpu_data_out = {32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C, 32'h4B5A6978};
    for (int k = 0; k < 4; k++) cycle();
    check("rdc_second_issued", 256'(n5), 256'(2));
    check("rdc_second_data", 256'(rsp_data),
          256'({32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C, 32'h4B5A6978}));
    rsp_ready = 1'b1;
    cycle(); cycle();
    rsp_ready = 1'b0;

    // Illegal opcode
    send(3'd7, 4'd4, 1'b1, rnd_data());
    cycle();
    check("illegal_err", 256'(err), 256'(1));
    check("illegal_opcode", 256'(tpu_opcode), 256'(0));
    cycle();
    check("illegal_err_clear", 256'(err), 256'(0));

    // Random traffic
    for (int k = 0; k < 300; k++) begin
      cmd_valid = ($urandom_range(0, 9) < 7);
      cmd_op = rnd_op();
      cmd_idx = 4'($urandom);
      cmd_hl = 1'($urandom);
      cmd_data = rnd_data();
      rsp_ready = ($urandom_range(0, 3) == 0);
      tpu_data_out = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 120; k++) cycle();
    rsp_ready = 1'b0;

    // Reset in matmul cycle 10
    n4 = 0;
    send(3'd4, 4'd0, 1'b0, rnd_data());
    guard = 0;
    while (n4 < 10 && guard < 50) begin
      cycle();
      guard++;
    end
    check("mm_reach_cycle10", 256'(n4), 256'(10));
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    nd = 0;
    check("rst_opcode", 256'(tpu_opcode), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_cmd_ready", 256'(cmd_ready), 256'(1));
    check("rst_mm_done", 256'(mm_done), 256'(0));
    check("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    cycle(); cycle();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) cycle();
    check("rst_no_mm_done", 256'(nd), 256'(0));
    for (int i = 0; i < DIM; i++) d[i] = 32'(i * 17);
    send(3'd1, 4'd3, 1'b0, d);
    cycle();
    check("post_rst_wra_opcode", 256'(tpu_opcode), 256'(1));
    check("post_rst_wra_vhigh3", 256'(tpu_v_high[3]), 256'(32'h77));
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
